// File: rtl/ram_req_ctrl_if.sv
// Client request/response handshake plus the RAM macro port, bundled for ram_req_ctrl.
// The slave modport is the controller's view and the master modport is the client/RAM side.
interface ram_req_ctrl_if #(
  parameter int W_ADDR = 13,
  parameter int W_DATA = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [W_ADDR-1:0] req_addr;
  logic [W_DATA-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W_DATA-1:0] rsp_data;
  logic              init_done;
  logic [W_ADDR-1:0] ram_address;
  logic [W_DATA-1:0] ram_data;
  logic              ram_wren;
  logic [W_DATA-1:0] ram_q;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready, ram_q,
    output req_ready, rsp_valid, rsp_data, init_done, ram_address, ram_data, ram_wren
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready, ram_q,
    input  req_ready, rsp_valid, rsp_data, init_done, ram_address, ram_data, ram_wren
  );
endinterface

// File: rtl/ram_req_ctrl.sv
// Request-side controller for the single-port working RAM: optional zero-fill after reset,
// then valid/ready request service with a 2-entry in-order read response buffer.
module ram_req_ctrl #(
  parameter int W_ADDR         = 13,
  parameter int W_DATA         = 16,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input logic           clk,
  input logic           rst,
  ram_req_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RST_WAIT = 2'd0,
    ST_INIT     = 2'd1,
    ST_RUN      = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [W_ADDR-1:0] r_init_cnt;
  logic              r_inflight;
  logic [W_DATA-1:0] r_fifo [2];
  logic              r_rd_ptr;
  logic              r_wr_ptr;
  logic [1:0]        r_count;

  logic              w_run;
  logic              w_push;
  logic              w_pop;
  logic [2:0]        w_occ;
  logic              w_ready;
  logic              w_accept;

  assign w_run    = (r_state == ST_RUN);
  assign w_push   = r_inflight;
  assign w_pop    = (r_count != 2'd0) & bus.rsp_ready;
  // Occupancy after this cycle's pop, counting the read whose data lands next edge;
  // applied to writes too so a write never overtakes a stalled read.
  assign w_occ    = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_ready  = w_run & (w_occ <= 3'd1);
  assign w_accept = bus.req_valid & w_ready;

  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = (r_count != 2'd0);
  assign bus.rsp_data  = r_fifo[r_rd_ptr];
  assign bus.init_done = w_run;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_RST_WAIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    bus.ram_address = '0;
    bus.ram_data    = '0;
    bus.ram_wren    = 1'b0;
    unique case (r_state)
      ST_RST_WAIT: begin
        w_state_nxt = CLEAR_ON_RESET ? ST_INIT : ST_RUN;
      end
      ST_INIT: begin
        bus.ram_address = r_init_cnt;
        bus.ram_wren    = 1'b1;
        if (r_init_cnt == '1) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        bus.ram_address = bus.req_addr;
        bus.ram_data    = bus.req_wdata;
        bus.ram_wren    = bus.req_write & w_accept;
      end
      default: begin
        w_state_nxt = ST_RST_WAIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_init_cnt <= '0;
    end else if (r_state == ST_INIT) begin
      r_init_cnt <= r_init_cnt + W_ADDR'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_accept & ~bus.req_write;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        r_fifo[i] <= '0;
      end
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= bus.ram_q;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Bench for ram_req_ctrl: one instance with zero-fill, one without, each backed by a RAM model,
// checked cycle by cycle against a memory-array plus expected-response-queue reference.
module tb_ram_req_ctrl;
  localparam int W_ADDR      = 13;
  localparam int W_DATA      = 16;
  localparam int DEPTH       = 1 << W_ADDR;
  localparam int INIT_CYCLES = DEPTH + 1;
  localparam int VW          = 2 + W_DATA + 1 + W_ADDR + W_DATA;

  typedef logic [W_ADDR-1:0] addr_t;
  typedef logic [W_DATA-1:0] data_t;
  typedef struct { data_t data; int vis; } rsp_t;
  typedef struct { logic [VW-1:0] exp_v; logic [VW-1:0] act_v; bit acc; bit pop_seen; data_t pop_data; } obs_t;
  typedef struct { bit v; bit w; addr_t a; data_t d; bit rr; } step_t;

  logic clk   = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  data_t ram_a [DEPTH];
  data_t ram_b [DEPTH];
  data_t ref_a [DEPTH];
  data_t ref_b [DEPTH];
  rsp_t  q_a [$];
  rsp_t  q_b [$];
  bit    done_a = 1'b0;
  bit    done_b = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_req_ctrl_if #(.W_ADDR(W_ADDR), .W_DATA(W_DATA)) bus_a ();
  ram_req_ctrl_if #(.W_ADDR(W_ADDR), .W_DATA(W_DATA)) bus_b ();

  ram_req_ctrl #(.W_ADDR(W_ADDR), .W_DATA(W_DATA), .CLEAR_ON_RESET(1'b1)) u_dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  ram_req_ctrl #(.W_ADDR(W_ADDR), .W_DATA(W_DATA), .CLEAR_ON_RESET(1'b0)) u_dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  // Single-port RAM with registered read address: q follows the address sampled at the edge.
  always @(posedge clk) begin
    if (bus_a.ram_wren) ram_a[bus_a.ram_address] <= bus_a.ram_data;
    bus_a.ram_q <= ram_a[bus_a.ram_address];
    if (bus_b.ram_wren) ram_b[bus_b.ram_address] <= bus_b.ram_data;
    bus_b.ram_q <= ram_b[bus_b.ram_address];
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram_a[i] <= data_t'(i ^ 16'h5a5a);
      ram_b[i] <= data_t'(i * 3 + 16'h0100);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion before it");
    $fatal(1, "watchdog");
  end

  function automatic step_t mk(input bit v, input bit w, input int a, input int d, input bit rr);
    step_t s;
    s.v = v; s.w = w; s.a = addr_t'(a); s.d = data_t'(d); s.rr = rr;
    return s;
  endfunction

  // Drive one cycle, form expected/actual observation vectors, advance the reference, step a clock.
  task automatic apply(input bit sel, input step_t s, output obs_t o);
    int    sz;
    bit    hv, pop, e_rdy, acc, done;
    data_t hd;
    logic  a_rdy, a_rv, a_wren;
    data_t a_rd, a_wd;
    addr_t a_ad;
    addr_t e_ad;
    data_t e_wd;
    if (!sel) begin
      bus_a.req_valid = s.v; bus_a.req_write = s.w; bus_a.req_addr = s.a;
      bus_a.req_wdata = s.d; bus_a.rsp_ready = s.rr;
    end else begin
      bus_b.req_valid = s.v; bus_b.req_write = s.w; bus_b.req_addr = s.a;
      bus_b.req_wdata = s.d; bus_b.rsp_ready = s.rr;
    end
    #1;
    hd = '0;
    if (!sel) begin
      sz = q_a.size(); hv = (sz > 0) && (q_a[0].vis <= cyc);
      if (hv) hd = q_a[0].data;
      done = done_a;
      a_rdy = bus_a.req_ready; a_rv = bus_a.rsp_valid; a_rd = bus_a.rsp_data;
      a_wren = bus_a.ram_wren; a_ad = bus_a.ram_address; a_wd = bus_a.ram_data;
    end else begin
      sz = q_b.size(); hv = (sz > 0) && (q_b[0].vis <= cyc);
      if (hv) hd = q_b[0].data;
      done = done_b;
      a_rdy = bus_b.req_ready; a_rv = bus_b.rsp_valid; a_rd = bus_b.rsp_data;
      a_wren = bus_b.ram_wren; a_ad = bus_b.ram_address; a_wd = bus_b.ram_data;
    end
    pop   = hv && s.rr;
    e_rdy = done && ((sz - int'(pop)) <= 1);
    acc   = s.v && e_rdy;
    e_ad  = acc ? s.a : addr_t'(0);
    e_wd  = (acc && s.w) ? s.d : data_t'(0);
    o.exp_v = {e_rdy, hv, hd, acc && s.w, e_ad, e_wd};
    o.act_v = {a_rdy, a_rv, hv ? a_rd : data_t'(0), a_wren,
               acc ? a_ad : addr_t'(0), (acc && s.w) ? a_wd : data_t'(0)};
    o.acc      = acc;
    o.pop_seen = (a_rv === 1'b1) && s.rr;
    o.pop_data = a_rd;
    if (!sel) begin
      if (pop) void'(q_a.pop_front());
      if (acc) begin
        if (s.w) ref_a[s.a] = s.d;
        else     q_a.push_back('{ref_a[s.a], cyc + 2});
      end
    end else begin
      if (pop) void'(q_b.pop_front());
      if (acc) begin
        if (s.w) ref_b[s.a] = s.d;
        else     q_b.push_back('{ref_b[s.a], cyc + 2});
      end
    end
    @(negedge clk);
  endtask

  // Release reset and count cycles until init_done, while offering a request that must be ignored.
  task automatic count_init(input bit sel, output int n, output logic [W_ADDR+W_DATA:0] first,
                            output addr_t mid, output bit rdy_seen);
    n = 0; first = '0; mid = '0; rdy_seen = 1'b0;
    @(negedge clk);
    if (!sel) begin
      rst_a = 1'b1;
      bus_a.req_valid = 1'b1; bus_a.req_write = 1'b1; bus_a.req_addr = addr_t'(10);
      bus_a.req_wdata = 16'hFFFF; bus_a.rsp_ready = 1'b1;
    end else begin
      rst_b = 1'b1;
      bus_b.req_valid = 1'b1; bus_b.req_write = 1'b1; bus_b.req_addr = addr_t'(10);
      bus_b.req_wdata = 16'hFFFF; bus_b.rsp_ready = 1'b1;
    end
    while (n < 3 * DEPTH) begin
      @(negedge clk);
      n++;
      if (!sel) begin
        if (n == 1) first = {bus_a.ram_wren, bus_a.ram_address, bus_a.ram_data};
        if (n == 100) mid = bus_a.ram_address;
        if (bus_a.init_done === 1'b1) break;
        if (bus_a.req_ready !== 1'b0) rdy_seen = 1'b1;
      end else begin
        if (n == 1) first = {bus_b.ram_wren, bus_b.ram_address, bus_b.ram_data};
        if (bus_b.init_done === 1'b1) break;
        if (bus_b.req_ready !== 1'b0) rdy_seen = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({bus_a.req_ready, bus_a.rsp_valid, bus_a.init_done, bus_a.ram_wren} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl_a: got %b required 0000", {bus_a.req_ready, bus_a.rsp_valid, bus_a.init_done, bus_a.ram_wren});
    end
    n_checks++;
    if ({bus_a.ram_address, bus_a.ram_data, bus_a.rsp_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_data_a: got addr %h data %h rsp %h required all zero", bus_a.ram_address, bus_a.ram_data, bus_a.rsp_data);
    end
    n_checks++;
    if ({bus_b.req_ready, bus_b.rsp_valid, bus_b.init_done, bus_b.ram_wren, bus_b.ram_address, bus_b.ram_data, bus_b.rsp_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_b: got ctrl %b addr %h data %h rsp %h required all zero",
               {bus_b.req_ready, bus_b.rsp_valid, bus_b.init_done, bus_b.ram_wren}, bus_b.ram_address, bus_b.ram_data, bus_b.rsp_data);
    end
  endtask

  task automatic test_init_clear();
    int n; logic [W_ADDR+W_DATA:0] first; addr_t mid; bit rdy_seen;
    obs_t o; step_t s[$]; data_t got[$]; data_t ex[2];
    count_init(1'b0, n, first, mid, rdy_seen);
    n_checks++;
    if (n != INIT_CYCLES) begin n_fail++; $display("FAIL init_len: got %0d cycles required %0d", n, INIT_CYCLES); end
    n_checks++;
    if (first !== {1'b1, addr_t'(0), data_t'(0)}) begin n_fail++; $display("FAIL init_first: got %h required wren=1 addr=0 data=0", first); end
    n_checks++;
    if (mid !== addr_t'(99)) begin n_fail++; $display("FAIL init_counter: got %h required %h", mid, addr_t'(99)); end
    n_checks++;
    if (rdy_seen) begin n_fail++; $display("FAIL init_ready: got req_ready=1 during init required 0"); end
    for (int i = 0; i < DEPTH; i++) ref_a[i] = '0;
    q_a.delete();
    done_a = 1'b1;
    s.push_back(mk(1, 0, 10, 0, 1));
    s.push_back(mk(1, 0, DEPTH - 1, 0, 1));
    repeat (3) s.push_back(mk(0, 0, 0, 0, 1));
    foreach (s[i]) begin
      apply(1'b0, s[i], o);
      n_checks++;
      if (o.act_v !== o.exp_v) begin n_fail++; $display("FAIL init_read step %0d: got %h required %h", i, o.act_v, o.exp_v); end
      if (o.pop_seen) got.push_back(o.pop_data);
    end
    ex[0] = 16'h0000; ex[1] = 16'h0000;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (i >= got.size() || got[i] !== ex[i]) begin
        n_fail++; $display("FAIL init_read_data %0d: got %h (of %0d) required %h", i, (i < got.size()) ? got[i] : 16'hxxxx, got.size(), ex[i]);
      end
    end
  endtask

  task automatic test_write_read();
    obs_t o; step_t s[$]; data_t got[$]; int at[$]; data_t ex[5]; int ex_at[5];
    s.push_back(mk(1, 1, 11, 16'h8114, 1));
    s.push_back(mk(1, 1, 12, 16'h2677, 1));
    s.push_back(mk(1, 0, 12, 0, 1));
    s.push_back(mk(1, 0, 11, 0, 1));
    s.push_back(mk(1, 0, 12, 0, 1));
    s.push_back(mk(1, 0, 10, 0, 1));
    s.push_back(mk(0, 0, 0, 0, 1));
    s.push_back(mk(0, 0, 0, 0, 1));
    s.push_back(mk(1, 1, 5, 16'hBEEF, 1));
    s.push_back(mk(1, 0, 5, 0, 1));
    repeat (3) s.push_back(mk(0, 0, 0, 0, 1));
    foreach (s[i]) begin
      apply(1'b0, s[i], o);
      n_checks++;
      if (o.act_v !== o.exp_v) begin n_fail++; $display("FAIL write_read step %0d: got %h required %h", i, o.act_v, o.exp_v); end
      if (o.pop_seen) begin got.push_back(o.pop_data); at.push_back(i); end
    end
    ex[0] = 16'h2677; ex[1] = 16'h8114; ex[2] = 16'h2677; ex[3] = 16'h0000; ex[4] = 16'hBEEF;
    ex_at[0] = 4; ex_at[1] = 5; ex_at[2] = 6; ex_at[3] = 7; ex_at[4] = 11;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (i >= got.size() || got[i] !== ex[i] || at[i] != ex_at[i]) begin
        n_fail++;
        $display("FAIL write_read_rsp %0d: got %h at step %0d (of %0d) required %h at step %0d",
                 i, (i < got.size()) ? got[i] : 16'hxxxx, (i < at.size()) ? at[i] : -1, got.size(), ex[i], ex_at[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    obs_t o; data_t got[$]; addr_t ba[3]; data_t ex[3]; int idx;
    ba[0] = addr_t'(11); ba[1] = addr_t'(12); ba[2] = addr_t'(10);
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      apply(1'b0, mk(idx < 3, 0, ba[(idx < 3) ? idx : 2], 0, 0), o);
      n_checks++;
      if (o.act_v !== o.exp_v) begin n_fail++; $display("FAIL bp_hold cyc %0d: got %h required %h", c, o.act_v, o.exp_v); end
      if (o.acc) idx++;
    end
    #1;
    n_checks++;
    if (idx != 2 || bus_a.req_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_stall: got %0d accepted, req_ready=%b required 2 accepted, req_ready=0", idx, bus_a.req_ready);
    end
    for (int c = 0; c < 8; c++) begin
      apply(1'b0, mk(idx < 3, 0, ba[(idx < 3) ? idx : 2], 0, 1), o);
      n_checks++;
      if (o.act_v !== o.exp_v) begin n_fail++; $display("FAIL bp_release cyc %0d: got %h required %h", c, o.act_v, o.exp_v); end
      if (o.acc) idx++;
      if (o.pop_seen) got.push_back(o.pop_data);
    end
    ex[0] = 16'h8114; ex[1] = 16'h2677; ex[2] = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (i >= got.size() || got[i] !== ex[i]) begin
        n_fail++; $display("FAIL bp_rsp %0d: got %h (of %0d) required %h", i, (i < got.size()) ? got[i] : 16'hxxxx, got.size(), ex[i]);
      end
    end
  endtask

  task automatic test_random(input bit sel, input int n);
    obs_t o; step_t s;
    for (int c = 0; c < n; c++) begin
      s.v  = ($urandom % 4) != 0;
      s.w  = $urandom % 2;
      s.a  = (($urandom % 8) == 0) ? addr_t'($urandom) : addr_t'($urandom_range(0, 15));
      s.d  = data_t'($urandom);
      s.rr = ($urandom % 4) != 0;
      apply(sel, s, o);
      n_checks++;
      if (o.act_v !== o.exp_v) begin n_fail++; $display("FAIL random_%0d cyc %0d: got %h required %h", sel, c, o.act_v, o.exp_v); end
    end
    for (int c = 0; c < 4; c++) begin
      apply(sel, mk(0, 0, 0, 0, 1), o);
      n_checks++;
      if (o.act_v !== o.exp_v) begin n_fail++; $display("FAIL random_drain_%0d cyc %0d: got %h required %h", sel, c, o.act_v, o.exp_v); end
    end
  endtask

  task automatic test_async_reset();
    obs_t o; int n; logic [W_ADDR+W_DATA:0] first; addr_t mid; bit rdy_seen; int w; data_t got[$];
    apply(1'b0, mk(1, 0, 11, 0, 0), o);
    apply(1'b0, mk(1, 0, 12, 0, 0), o);
    apply(1'b0, mk(0, 0, 0, 0, 0), o);
    apply(1'b0, mk(0, 0, 0, 0, 0), o);
    n_checks++;
    if (o.act_v !== o.exp_v) begin n_fail++; $display("FAIL areset_fill: got %h required %h", o.act_v, o.exp_v); end
    bus_a.req_valid = 1'b1; bus_a.req_write = 1'b1; bus_a.req_addr = addr_t'(20);
    bus_a.req_wdata = 16'h1111; bus_a.rsp_ready = 1'b1;
    #1;
    n_checks++;
    if ({bus_a.rsp_valid, bus_a.req_ready, bus_a.ram_wren} !== 3'b111) begin
      n_fail++; $display("FAIL areset_pre: got %b required 111", {bus_a.rsp_valid, bus_a.req_ready, bus_a.ram_wren});
    end
    #1 rst_a = 1'b0; done_a = 1'b0;
    #1;
    n_checks++;
    if ({bus_a.rsp_valid, bus_a.req_ready, bus_a.ram_wren, bus_a.init_done, bus_a.ram_address, bus_a.rsp_data} !== '0) begin
      n_fail++; $display("FAIL areset_drop: got ctrl %b addr %h rsp %h required all zero",
                         {bus_a.rsp_valid, bus_a.req_ready, bus_a.ram_wren, bus_a.init_done}, bus_a.ram_address, bus_a.rsp_data);
    end
    count_init(1'b0, n, first, mid, rdy_seen);
    n_checks++;
    if (n != INIT_CYCLES || first !== {1'b1, addr_t'(0), data_t'(0)}) begin
      n_fail++; $display("FAIL areset_reinit: got %0d cycles first %h required %0d cycles first wren=1 addr=0", n, first, INIT_CYCLES);
    end
    // Second reset lands in the middle of the zero-fill.
    @(negedge clk); rst_a = 1'b0;
    @(negedge clk); rst_a = 1'b1;
    w = 0;
    while (w < 2 * DEPTH && bus_a.ram_address !== addr_t'(4000)) begin @(negedge clk); w++; end
    n_checks++;
    if (bus_a.ram_address !== addr_t'(4000) || bus_a.ram_wren !== 1'b1) begin
      n_fail++; $display("FAIL areset_init_reach: got addr %h wren %b required addr %h wren 1", bus_a.ram_address, bus_a.ram_wren, addr_t'(4000));
    end
    #2 rst_a = 1'b0;
    #1;
    n_checks++;
    if ({bus_a.ram_wren, bus_a.ram_address, bus_a.init_done} !== '0) begin
      n_fail++; $display("FAIL areset_init_drop: got wren %b addr %h done %b required 0", bus_a.ram_wren, bus_a.ram_address, bus_a.init_done);
    end
    count_init(1'b0, n, first, mid, rdy_seen);
    n_checks++;
    if (n != INIT_CYCLES || first !== {1'b1, addr_t'(0), data_t'(0)} || mid !== addr_t'(99)) begin
      n_fail++; $display("FAIL areset_restart: got %0d cycles first %h mid %h required %0d cycles from addr 0", n, first, mid, INIT_CYCLES);
    end
    for (int i = 0; i < DEPTH; i++) ref_a[i] = '0;
    q_a.delete();
    done_a = 1'b1;
    apply(1'b0, mk(1, 0, 11, 0, 1), o);
    apply(1'b0, mk(1, 0, 20, 0, 1), o);
    for (int c = 0; c < 3; c++) begin
      apply(1'b0, mk(0, 0, 0, 0, 1), o);
      if (o.pop_seen) got.push_back(o.pop_data);
    end
    n_checks++;
    if (got.size() != 2 || got[0] !== 16'h0000 || got[1] !== 16'h0000) begin
      n_fail++; $display("FAIL areset_cleared: got %0d responses first %h required 2 responses of 0000", got.size(), (got.size() > 0) ? got[0] : 16'hxxxx);
    end
  endtask

  task automatic test_no_clear();
    int n; logic [W_ADDR+W_DATA:0] first; addr_t mid; bit rdy_seen;
    obs_t o; step_t s[$]; data_t got[$]; data_t ex[6];
    count_init(1'b1, n, first, mid, rdy_seen);
    n_checks++;
    if (n != 1) begin n_fail++; $display("FAIL noclear_len: got %0d cycles required 1", n); end
    q_b.delete();
    done_b = 1'b1;
    s.push_back(mk(1, 1, 7, 16'h1234, 1));
    s.push_back(mk(1, 1, 8, 16'h5678, 1));
    s.push_back(mk(1, 0, 7, 0, 1));
    s.push_back(mk(1, 0, 8, 0, 1));
    s.push_back(mk(1, 0, 7, 0, 1));
    s.push_back(mk(1, 0, 8, 0, 1));
    s.push_back(mk(1, 0, 100, 0, 1));
    s.push_back(mk(1, 0, 7, 0, 1));
    repeat (3) s.push_back(mk(0, 0, 0, 0, 1));
    foreach (s[i]) begin
      apply(1'b1, s[i], o);
      n_checks++;
      if (o.act_v !== o.exp_v) begin n_fail++; $display("FAIL noclear step %0d: got %h required %h", i, o.act_v, o.exp_v); end
      if (o.pop_seen) got.push_back(o.pop_data);
    end
    ex[0] = 16'h1234; ex[1] = 16'h5678; ex[2] = 16'h1234; ex[3] = 16'h5678; ex[4] = 16'h022C; ex[5] = 16'h1234;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (i >= got.size() || got[i] !== ex[i]) begin
        n_fail++; $display("FAIL noclear_rsp %0d: got %h (of %0d) required %h", i, (i < got.size()) ? got[i] : 16'hxxxx, got.size(), ex[i]);
      end
    end
  endtask

  initial begin
    bus_a.req_valid = 1'b0; bus_a.req_write = 1'b0; bus_a.req_addr = '0; bus_a.req_wdata = '0; bus_a.rsp_ready = 1'b0;
    bus_b.req_valid = 1'b0; bus_b.req_write = 1'b0; bus_b.req_addr = '0; bus_b.req_wdata = '0; bus_b.rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ref_a[i] = '0;
      ref_b[i] = data_t'(i * 3 + 16'h0100);
    end
    repeat (3) @(negedge clk);
    test_reset();
    test_init_clear();
    test_write_read();
    test_backpressure();
    test_random(1'b0, 500);
    test_async_reset();
    test_no_clear();
    test_random(1'b1, 300);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_req_ctrl.md
# ram_req_ctrl

Request-side controller for the single-port 8192×16 working RAM (`RAM_8192` FPGA macro or the ASIC equivalent). It initiates every RAM access on behalf of one client. It accepts read and write requests over a valid/ready interface, drives address, write data and write-enable into the RAM, and absorbs the RAM's one-cycle read latency. Read data returns through a 2-entry response buffer with backpressure. After reset it can optionally clear the whole RAM to zero before accepting requests.

## Interface
Parameters:
- `W_ADDR`, 13, RAM address width; depth = 2**W_ADDR
- `W_DATA`, 16, RAM data width
- `CLEAR_ON_RESET`, 1, 1 = zero-fill all locations after reset; 0 = go straight to service

Ports:
- `clk`  in  1  clock; all state updates on posedge
- `rst`  in  1  reset; one clock domain; reset is asynchronous and active-low
- `req_valid`  in  1  client request present
- `req_ready`  out  1  controller accepts request this cycle
- `req_write`  in  1  1 = write, 0 = read
- `req_addr`  in  W_ADDR  request address
- `req_wdata`  in  W_DATA  write data, ignored for reads
- `rsp_valid`  out  1  read data available at buffer head
- `rsp_ready`  in  1  client consumes head this cycle
- `rsp_data`  out  W_DATA  read data, in request order
- `init_done`  out  1  high once in RUN
- `ram_address`  out  W_ADDR  to RAM `address`
- `ram_data`  out  W_DATA  to RAM `data`
- `ram_wren`  out  1  to RAM `wren`
- `ram_q`  in  W_DATA  from RAM `q`; valid the cycle after the edge that sampled a read address

## Operation
- States: RST_WAIT (reset value), INIT, RUN.
- RST_WAIT: one cycle after reset release. Next state is INIT if `CLEAR_ON_RESET`=1, else RUN.
- INIT:
  - `ram_wren`=1, `ram_data`=0, `ram_address`=init counter.
  - The counter runs from 0 and increments every cycle.
  - After the edge that writes address 2**W_ADDR−1, go to RUN. The counter wraps to 0 and is not used again.
- RUN: `ram_address`/`ram_data`/`ram_wren` are combinational from `req_addr`/`req_wdata`/(`req_write` & accept).
  - Accept = `req_valid` & `req_ready`.
  - When there is no accept, `ram_wren`=0 and the address is don't-care.
- Read pipeline:
  - An accepted read sets the `inflight` flag at that edge.
  - On the next edge, `ram_q` is pushed into the response FIFO. Depth 2, in order.
- `req_ready` = (state==RUN) & (fifo_count + inflight − (rsp_valid & rsp_ready) ≤ 1).
  - The same rule applies to reads and writes; writes are held during read backpressure to preserve ordering.
  - `req_ready` is combinational from `rsp_ready`.
- FIFO:
  - `rsp_valid` = fifo_count≠0, and `rsp_data` = head.
  - A push and a pop in the same cycle both take effect.
  - The FIFO never overflows, because `req_ready` guarantees it.
- `init_done` = (state==RUN).

## Timing
- Values during reset (`rst` low) and in RST_WAIT:
  - `req_ready`=0, `rsp_valid`=0, `init_done`=0, `ram_wren`=0.
  - `ram_address`=0, `ram_data`=0, `rsp_data`=0.
  - FIFO empty, `inflight`=0, init counter 0.
- Init duration:
  - 1 + 2**W_ADDR cycles from reset release to `init_done`, i.e. 8193 cycles at defaults.
  - With `CLEAR_ON_RESET`=0 it is 1 cycle.
- Read latency:
  - A read accepted at edge E raises `rsp_valid` after edge E+1, provided the FIFO was not full of unconsumed data.
  - Write-then-read of the same address on consecutive edges returns the new data.
- Throughput: 1 request/cycle sustained while `rsp_ready`=1.
- Backpressure with `rsp_ready`=0: at most 2 reads are outstanding, after which `req_ready`=0. The client must hold its request stable until accepted.
- Async reset asserted mid-operation:
  - Everything returns to reset values immediately.
  - In-flight and buffered reads are discarded.
  - INIT restarts from address 0 after release.
- During INIT, `req_valid` is ignored; no request is lost because `req_ready`=0.

## Test plan
1. Reset with `CLEAR_ON_RESET`=1 -> `init_done` rises exactly 8193 cycles after release. A subsequent read of addresses 10 and 8191 returns 0x0000.
2. Write 11←0x8114, write 12←0x2677, then reads 12, 11, 12, 10 on consecutive cycles with `rsp_ready`=1 -> responses 0x2677, 0x8114, 0x2677, 0x0000 on consecutive cycles, the first one cycle after the read of 12 is accepted.
3. Hold `rsp_ready`=0 and issue reads of 11, 12, 10 -> only two are accepted and `req_ready` stays 0. Raising `rsp_ready` yields 0x8114, 0x2677, then the third read is accepted and returns 0x0000.
4. Write 5←0xBEEF on edge E and read 5 on edge E+1 -> `rsp_data`=0xBEEF after edge E+2.
5. Assert `rst` low with 2 responses buffered and at init address 4000 in a separate run -> `rsp_valid`/`req_ready`/`ram_wren` drop immediately. After release, INIT restarts at address 0 and takes the full 8193 cycles.
6. `CLEAR_ON_RESET`=0 -> `init_done` 1 cycle after release. A push and a pop in the same cycle keep fifo_count unchanged and preserve order.
